// File: rtl/dlx_inst_encoder_pkg.sv
// Shared encoder definitions: format codes, instruction field positions,
// opcode constants and the field-packing function.
package dlx_inst_encoder_pkg;

  typedef enum logic [1:0] {
    ENC_FMT_R   = 2'd0,
    ENC_FMT_I   = 2'd1,
    ENC_FMT_J   = 2'd2,
    ENC_FMT_NOP = 2'd3
  } enc_fmt_e;

  // Field bit positions within the 32-bit DLX word
  localparam int OPC_HI   = 31, OPC_LO   = 26;
  localparam int RS1_HI   = 25, RS1_LO   = 21;
  localparam int RS2_HI   = 20, RS2_LO   = 16;
  localparam int RDR_HI   = 15, RDR_LO   = 11;   // rd in R format
  localparam int RDI_HI   = 20, RDI_LO   = 16;   // rd in I format
  localparam int IMM_HI   = 15, IMM_LO   = 0;
  localparam int VAL_HI   = 25, VAL_LO   = 0;
  localparam int FUNC_HI  = 5,  FUNC_LO  = 0;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;    // R-type primary opcode
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic        illegal;
  } enc_res_t;

  // Pack one field set. I/J with opcode 0 collide with the R-type space,
  // so they are flagged illegal and replaced by a NOP.
  function automatic enc_res_t encode(
    input enc_fmt_e    fmt,
    input logic [5:0]  opcode,
    input logic [5:0]  func,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] value
  );
    enc_res_t r;
    r.inst    = NOP_WORD;
    r.illegal = 1'b0;
    case (fmt)
      ENC_FMT_R: begin
        r.inst[OPC_HI:OPC_LO]   = OPC_SPECIAL;
        r.inst[RS1_HI:RS1_LO]   = rs1;
        r.inst[RS2_HI:RS2_LO]   = rs2;
        r.inst[RDR_HI:RDR_LO]   = rd;
        r.inst[FUNC_HI:FUNC_LO] = func;
      end
      ENC_FMT_I: begin
        if (opcode == OPC_SPECIAL) begin
          r.illegal = 1'b1;
        end else begin
          r.inst[OPC_HI:OPC_LO] = opcode;
          r.inst[RS1_HI:RS1_LO] = rs1;
          r.inst[RDI_HI:RDI_LO] = rd;
          r.inst[IMM_HI:IMM_LO] = imm;
        end
      end
      ENC_FMT_J: begin
        if (opcode == OPC_SPECIAL) begin
          r.illegal = 1'b1;
        end else begin
          r.inst[OPC_HI:OPC_LO] = opcode;
          r.inst[VAL_HI:VAL_LO] = value;
        end
      end
      default: r.inst = NOP_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dlx_inst_encoder_fifo.sv
// inst_word_fifo: synchronous FIFO with wrap-bit pointers and an occupancy
// output. The head is shown combinationally; when empty, the last popped
// entry is shown instead so the output holds its value.
module inst_word_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  import dlx_inst_encoder_pkg::*;

  localparam int LW = $clog2(DEPTH);
  localparam logic [LW:0] FULL_LVL = (LW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [LW:0]   wptr_q, rptr_q;
  logic [DW-1:0] last_q;
  logic          push_ok, pop_ok;

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == FULL_LVL);
  assign empty_o = (level_o == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? last_q : mem_q[rptr_q[LW-1:0]];

  // Storage write; contents need no reset since empty shows last_q
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[LW-1:0]] <= wdata_i;
  end

  // Pointer advance and last-popped capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
        last_q <= mem_q[rptr_q[LW-1:0]];
      end
    end
  end

endmodule

// File: rtl/dlx_inst_encoder.sv
// DLX instruction encoder: packs field sets into 32-bit words, tags them
// with a running instruction-memory address and queues them for the
// memory write side.
module dlx_inst_encoder
  import dlx_inst_encoder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_fmt,
  input  logic [5:0]             in_opcode,
  input  logic [5:0]             in_func,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [4:0]             in_rd,
  input  logic [15:0]            in_imm,
  input  logic [25:0]            in_value,
  input  logic                   base_load,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_sticky,
  input  logic                   err_clr
);

  localparam int DW = ADDR_W + 32;

  enc_res_t          enc;
  logic              accept, full, empty;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, tag;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata;

  assign enc = encode(enc_fmt_e'(in_fmt), in_opcode, in_func, in_rs1, in_rs2,
                      in_rd, in_imm, in_value);

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign tag      = base_load ? base_addr : next_addr_q;

  // Next address and sticky error; a new error outranks a clear
  always_comb begin
    next_addr_d = next_addr_q;
    err_d       = err_q;
    if (accept)         next_addr_d = tag + ADDR_W'(ADDR_STEP);
    else if (base_load) next_addr_d = base_addr;
    if (accept && enc.illegal) err_d = 1'b1;
    else if (err_clr)          err_d = 1'b0;
  end

  // Address counter and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
    end
  end

  inst_word_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i ({tag, enc.inst}),
    .pop_i   (out_ready),
    .rdata_o (rdata),
    .empty_o (empty),
    .full_o  (full),
    .level_o (level)
  );

  assign out_valid  = ~empty;
  assign out_inst   = rdata[31:0];
  assign out_addr   = rdata[DW-1:32];
  assign err_sticky = err_q;

endmodule

// File: tb/tb_dlx_inst_encoder.sv
// Directed bench for dlx_inst_encoder: a table of single-word encodes
// followed by hand sequences for backpressure, address wrap, error flag
// and asynchronous reset.
module tb_dlx_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_fmt;
  logic [5:0]  in_opcode, in_func;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_value;
  logic        base_load;
  logic [31:0] base_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_addr;
  logic [2:0]  level;
  logic        err_sticky, err_clr;

  dlx_inst_encoder #(.DEPTH(4), .ADDR_W(32), .ADDR_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_value(in_value), .base_load(base_load), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .level(level), .err_sticky(err_sticky),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] imm;
    logic [25:0] value;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[6];
  logic [31:0] exp_addr;
  logic [31:0] words[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_fields(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.opcode; in_func = v.func;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
    in_imm = v.imm; in_value = v.value;
  endtask

  // Present one field set for a single edge, then sample 1 time unit later
  task automatic push(input vec_t v);
    set_fields(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] f, input logic [5:0] op,
      input logic [5:0] fn, input logic [4:0] a, input logic [4:0] b,
      input logic [4:0] d, input logic [15:0] im, input logic [25:0] va,
      input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = f; v.opcode = op; v.func = fn; v.rs1 = a; v.rs2 = b; v.rd = d;
    v.imm = im; v.value = va; v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(2'd0, 6'h00, 6'h20, 5'd1,  5'd2, 5'd3,  16'h0,    26'h0,       32'h0022_1820, 1'b0);
    vecs[1] = mk(2'd1, 6'h08, 6'h00, 5'd4,  5'd0, 5'd5,  16'hFFFF, 26'h0,       32'h2085_FFFF, 1'b0);
    vecs[2] = mk(2'd2, 6'h02, 6'h00, 5'd0,  5'd0, 5'd0,  16'h0,    26'h3FF_FFFF, 32'h0BFF_FFFF, 1'b0);
    vecs[3] = mk(2'd3, 6'h2A, 6'h15, 5'd7,  5'd9, 5'd11, 16'hABCD, 26'h123_4567, 32'h0000_0000, 1'b0);
    vecs[4] = mk(2'd0, 6'h3F, 6'h3F, 5'd31, 5'd0, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 32'h03E0_F83F, 1'b0);
    vecs[5] = mk(2'd1, 6'h23, 6'h00, 5'd2,  5'd0, 5'd7,  16'h1234, 26'h0,       32'h8C47_1234, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; base_load = 1'b0;
    base_addr = '0; err_clr = 1'b0;
    set_fields(vecs[0]);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst",  64'(out_inst),  64'd0);
    chk("rst_out_addr",  64'(out_addr),  64'd0);
    chk("rst_level",     64'(level),     64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_err",       64'(err_sticky), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: each word visible the cycle after its accepting edge
    exp_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      push(vecs[i]);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_inst", i),  64'(out_inst),  64'(vecs[i].exp_inst));
      chk($sformatf("tbl%0d_addr", i),  64'(out_addr),  64'(exp_addr));
      chk($sformatf("tbl%0d_level", i), 64'(level),     64'd1);
      chk($sformatf("tbl%0d_err", i),   64'(err_sticky), 64'(vecs[i].exp_err));
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk); #1;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("empty_hold_inst", 64'(out_inst), 64'(vecs[5].exp_inst));

    // Backpressure: fill to DEPTH, 5th waits until a pop frees a slot
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) words[i] = 32'h2022_0000 + 32'(i);
    for (int i = 0; i < 4; i++)
      push(mk(2'd1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd2, 16'(i), 26'h0, 32'h0, 1'b0));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_level",    64'(level),    64'd4);
    chk("full_head",     64'(out_inst), 64'(words[0]));
    chk("full_head_addr", 64'(out_addr), 64'(exp_addr));
    set_fields(mk(2'd1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd2, 16'd4, 26'h0, 32'h0, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("full_blocked_level", 64'(level),    64'd4);
    chk("full_stable_inst",   64'(out_inst), 64'(words[0]));
    out_ready = 1'b1;
    @(posedge clk); #1;   // pop w0 only; push blocked (was full)
    chk("pop1_level", 64'(level),    64'd3);
    chk("pop1_inst",  64'(out_inst), 64'(words[1]));
    chk("pop1_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;   // pop w1 and push w4 together
    in_valid = 1'b0;
    chk("pushpop_level", 64'(level),    64'd3);
    chk("pushpop_inst",  64'(out_inst), 64'(words[2]));
    for (int k = 3; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("order%0d_inst", k), 64'(out_inst), 64'(words[k]));
      chk($sformatf("order%0d_addr", k), 64'(out_addr), 64'(exp_addr + 32'(4*k)));
    end
    @(posedge clk); #1;
    chk("bp_empty_valid", 64'(out_valid), 64'd0);
    chk("bp_empty_level", 64'(level),     64'd0);
    exp_addr = exp_addr + 32'd20;

    // base_load on an accepting edge, then address wraps to zero
    base_load = 1'b1; base_addr = 32'hFFFF_FFFC;
    push(vecs[0]);
    base_load = 1'b0;
    chk("base_tag",  64'(out_addr), 64'h0000_0000_FFFF_FFFC);
    push(vecs[1]);
    chk("wrap_tag",  64'(out_addr), 64'd0);
    chk("wrap_inst", 64'(out_inst), 64'(vecs[1].exp_inst));
    // base_load without accept just reloads the counter
    base_load = 1'b1; base_addr = 32'h0000_1000;
    @(posedge clk); #1;
    base_load = 1'b0;
    push(vecs[2]);
    chk("reload_tag", 64'(out_addr), 64'h1000);

    // Illegal field sets and the sticky error flag
    push(mk(2'd1, 6'h00, 6'h00, 5'd3, 5'd0, 5'd4, 16'h5555, 26'h0, 32'h0, 1'b1));
    chk("illegal_inst", 64'(out_inst),  64'd0);
    chk("illegal_addr", 64'(out_addr),  64'h1004);
    chk("illegal_err",  64'(err_sticky), 64'd1);
    err_clr = 1'b1;
    push(mk(2'd2, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h155_5555, 32'h0, 1'b1));
    chk("clr_vs_err",   64'(err_sticky), 64'd1);
    chk("illegal_j",    64'(out_inst),  64'd0);
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_alone",    64'(err_sticky), 64'd0);

    // Asynchronous reset mid-transfer with level=3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(vecs[i]);
    chk("pre_rst_level", 64'(level), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level),     64'd0);
    chk("arst_ready", 64'(in_ready),  64'd1);
    chk("arst_inst",  64'(out_inst),  64'd0);
    #10 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    push(vecs[1]);
    chk("post_rst_addr", 64'(out_addr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
